// File: rtl/lsu_if.sv
// Core-side and memory-side signals of the load/store unit, bundled for the LSU ports.
// Handshake: a core request is held until core_stall_o is low; a memory request completes in any cycle that has mem_ready_i high.
interface lsu_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, core_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, core_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: aligns core accesses onto a 32-bit word bus, extends load data,
// and reports misaligned/illegal accesses and memory timeouts as a one-cycle error.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    lsu_if.slave       bus,
    output logic [1:0] state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam int unsigned   CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          req_ok;

    function automatic logic access_ok(input logic [2:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~a[0];
            SZ_W:        ok = (a == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << a;
            SZ_H, SZ_HU: be = a[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            SZ_B, SZ_BU: r = {4{wd[7:0]}};
            SZ_H, SZ_HU: r = {2{wd[15:0]}};
            default:     r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = {{24{b[7]}}, b};
            SZ_BU:   r = {24'd0, b};
            SZ_H:    r = {{16{h[15]}}, h};
            SZ_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_ok = access_ok(bus.core_size_i, bus.core_addr_i[1:0]);

    // Outputs in IDLE depend on the live request; in BUSY only on latched registers.
    always_comb begin
        bus.core_stall_o = 1'b0;
        bus.core_err_o   = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_be_o     = 4'b0000;
        bus.mem_addr_o   = 32'd0;
        bus.mem_wd_o     = 32'd0;
        case (state_q)
            IDLE: begin
                bus.core_stall_o = bus.core_req_i & req_ok;
                bus.core_err_o   = bus.core_req_i & ~req_ok;
            end
            BUSY: begin
                bus.core_stall_o = 1'b1;
                bus.mem_req_o    = 1'b1;
                bus.mem_we_o     = we_q;
                bus.mem_be_o     = byte_en(size_q, addr_q[1:0]);
                bus.mem_addr_o   = {addr_q[31:2], 2'b00};
                bus.mem_wd_o     = lane_wdata(size_q, wd_q);
            end
            DONE: begin
                bus.core_err_o = err_q;
            end
            default: ;
        endcase
        // Keep the core-facing strobes quiet for as long as reset is held.
        if (rst_i) begin
            bus.core_stall_o = 1'b0;
            bus.core_err_o   = 1'b0;
        end
    end

    assign bus.core_rd_o = rdata_q;
    assign state_o       = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.core_req_i && req_ok) begin
                    we_d    = bus.core_we_i;
                    size_d  = bus.core_size_i;
                    addr_d  = bus.core_addr_i;
                    wd_d    = bus.core_wd_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A ready arriving in the last allowed cycle wins over the timeout.
                if (bus.mem_ready_i) begin
                    if (!we_q) rdata_d = load_ext(size_q, addr_q[1:0], bus.mem_rd_i);
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!we_q) rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized accesses against a transaction-level model.
module tb_lsu;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         errors = 0;
    int         checks = 0;
    logic [31:0] exp_rd = 32'd0;
    logic [31:0] exp_q[$];

    lsu_if bus();

    lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---- reference model: rules written as plain arithmetic ----
    function automatic bit m_legal(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 32'(1) << (a % 4);
            3'd1, 3'd5: return 32'(3) << (2 * ((a / 2) % 2));
            default:    return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'd0:    return (wd % 256) * 32'h01010101;
            3'd1:    return (wd % 65536) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) % 256;
        h = (rd >> (16 * ((a / 2) % 2))) % 65536;
        case (sz)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // ---- driver: one complete core access; entered and left just after a rising edge ----
    task automatic do_access(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int delay);
        bit timed_out;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_size_i = sz;
        bus.core_addr_i = addr;
        bus.core_wd_i   = wd;
        bus.mem_ready_i = 1'($urandom_range(0, 1));
        bus.mem_rd_i    = $urandom;
        @(negedge clk);
        if (!m_legal(sz, addr)) begin
            check("illegal_err", 32'(bus.core_err_o), 32'd1);
            check("illegal_stall", 32'(bus.core_stall_o), 32'd0);
            check("illegal_mreq", 32'(bus.mem_req_o), 32'd0);
            @(posedge clk); #1;
            bus.core_req_i = 1'b0;
            @(negedge clk);
            check("illegal_err_pulse", 32'(bus.core_err_o), 32'd0);
            check("illegal_mreq_after", 32'(bus.mem_req_o), 32'd0);
            check("illegal_rd_kept", bus.core_rd_o, exp_rd);
            @(posedge clk); #1;
            return;
        end
        check("accept_stall", 32'(bus.core_stall_o), 32'd1);
        check("accept_err", 32'(bus.core_err_o), 32'd0);
        check("accept_mreq", 32'(bus.mem_req_o), 32'd0);
        @(posedge clk); #1;
        timed_out = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            bus.mem_ready_i = (k == delay);
            bus.mem_rd_i    = (k == delay) ? rd : $urandom;
            @(negedge clk);
            check("busy_mreq", 32'(bus.mem_req_o), 32'd1);
            check("busy_stall", 32'(bus.core_stall_o), 32'd1);
            check("busy_err", 32'(bus.core_err_o), 32'd0);
            check("busy_we", 32'(bus.mem_we_o), 32'(we));
            check("busy_be", 32'(bus.mem_be_o), m_be(sz, addr));
            check("busy_addr", bus.mem_addr_o, addr - (addr % 4));
            if (we) check("busy_wd", bus.mem_wd_o, m_wd(sz, wd));
            @(posedge clk); #1;
            if (k == delay) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'($urandom_range(0, 1));
        bus.mem_rd_i    = $urandom;
        if (!we) exp_rd = timed_out ? 32'd0 : m_load(sz, addr, rd);
        exp_q.push_back(exp_rd);
        @(negedge clk);
        check("done_stall", 32'(bus.core_stall_o), 32'd0);
        check("done_mreq", 32'(bus.mem_req_o), 32'd0);
        check("done_err", 32'(bus.core_err_o), 32'(timed_out));
        check("done_rd", bus.core_rd_o, exp_q.pop_front());
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic reset_in_busy();
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h10;
        bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
        end
        #1;
        check("rstbusy_pre_mreq", 32'(bus.mem_req_o), 32'd1);
        rst = 1'b1;
        #1;
        exp_rd = 32'd0;
        check("rstbusy_mreq", 32'(bus.mem_req_o), 32'd0);
        check("rstbusy_stall", 32'(bus.core_stall_o), 32'd0);
        check("rstbusy_rd", bus.core_rd_o, exp_rd);
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_mreq", 32'(bus.mem_req_o), 32'd0);
        check("post_rst_stall", 32'(bus.core_stall_o), 32'd0);
        check("post_rst_rd", bus.core_rd_o, exp_rd);
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b0;
    endtask

    initial begin
        logic [2:0] sz;
        bit         we;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd3;
        bus.core_addr_i = 32'h2;
        bus.core_wd_i   = 32'd0;
        bus.mem_rd_i    = 32'd0;
        bus.mem_ready_i = 1'b1;
        #2;
        check("rst_stall", 32'(bus.core_stall_o), 32'd0);
        check("rst_err", 32'(bus.core_err_o), 32'd0);
        check("rst_mreq", 32'(bus.mem_req_o), 32'd0);
        check("rst_mwe", 32'(bus.mem_we_o), 32'd0);
        check("rst_be", 32'(bus.mem_be_o), 32'd0);
        check("rst_addr", bus.mem_addr_o, 32'd0);
        check("rst_wd", bus.mem_wd_o, 32'd0);
        check("rst_rd", bus.core_rd_o, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        bus.core_req_i  = 1'b0;
        bus.mem_ready_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_mreq", 32'(bus.mem_req_o), 32'd0);
        check("idle_stall", 32'(bus.core_stall_o), 32'd0);
        @(posedge clk); #1;

        do_access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'd0, 0);
        do_access(1'b1, 3'd0, 32'h203, 32'h000000A5, 32'd0, 0);
        do_access(1'b1, 3'd1, 32'h306, 32'h1234BEEF, 32'd0, 3);
        do_access(1'b0, 3'd0, 32'h3, 32'd0, 32'h80FF1234, 0);
        check("lb_const", bus.core_rd_o, 32'hFFFFFF80);
        do_access(1'b0, 3'd4, 32'h3, 32'd0, 32'h80FF1234, 1);
        check("lbu_const", bus.core_rd_o, 32'h00000080);
        do_access(1'b0, 3'd1, 32'h2, 32'd0, 32'h80FF1234, 2);
        check("lh_const", bus.core_rd_o, 32'hFFFF80FF);
        do_access(1'b0, 3'd5, 32'h2, 32'd0, 32'h80FF1234, 0);
        check("lhu_const", bus.core_rd_o, 32'h000080FF);
        do_access(1'b0, 3'd2, 32'h0, 32'd0, 32'h80FF1234, 1);
        check("lw_const", bus.core_rd_o, 32'h80FF1234);
        do_access(1'b0, 3'd2, 32'h2, 32'd0, 32'd0, 0);
        do_access(1'b0, 3'd3, 32'h0, 32'd0, 32'd0, 0);
        do_access(1'b0, 3'd2, 32'h40, 32'd0, 32'h55AA55AA, TIMEOUT + 4);
        do_access(1'b0, 3'd2, 32'h44, 32'd0, 32'h12345678, TIMEOUT - 1);
        reset_in_busy();
        do_access(1'b0, 3'd2, 32'h48, 32'd0, 32'h0BADF00D, 1);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            if (we && (sz == 3'd4 || sz == 3'd5)) sz = sz - 3'd4;
            do_access(we, sz, $urandom, $urandom, $urandom, $urandom_range(0, TIMEOUT + 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, 16, number of BUSY cycles without mem_ready_i before a bus-error completion; SHALL be ≥2.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous reset, active-high.
REQ-005 core_req_i  input  1  core requests a data-memory access; held high until core_stall_o is low.
REQ-006 core_we_i  input  1  1 = store, 0 = load.
REQ-007 core_size_i  input  3  access size, funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU; 3/6/7 illegal.
REQ-008 core_addr_i  input  32  byte address.
REQ-009 core_wd_i  input  32  store data, right-aligned.
REQ-010 core_rd_o  output  32  load data, aligned and extended.
REQ-011 core_stall_o  output  1  core SHALL hold its state while high.
REQ-012 core_err_o  output  1  one-cycle error pulse for misaligned access, illegal size or timeout.
REQ-013 mem_req_o  output  1  memory request.
REQ-014 mem_we_o  output  1  memory write enable.
REQ-015 mem_be_o  output  4  byte enables, bit i = byte lane i.
REQ-016 mem_addr_o  output  32  word address, bits [1:0] = 0.
REQ-017 mem_wd_o  output  32  lane-replicated write data.
REQ-018 mem_rd_i  input  32  memory read word, valid when mem_ready_i = 1.
REQ-019 mem_ready_i  input  1  memory completes the current request.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 IDLE, core_req_i = 1, legal and aligned: latch we/size/addr/wd, core_stall_o = 1, go to BUSY.
REQ-022 IDLE, core_req_i = 1, illegal or misaligned (H/HU with addr[0] = 1; W with addr[1:0] ≠ 0): core_err_o = 1 in the same cycle, core_stall_o = 0, no memory request, stay in IDLE.
REQ-023 IDLE, core_req_i = 0: all memory outputs low or zero, core_stall_o = 0.
REQ-024 BUSY: mem_req_o = 1 and core_stall_o = 1; mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are driven from the latched registers only.
REQ-025 BUSY with mem_ready_i = 1: on a load, capture the extended data into rdata_q; go to DONE.
REQ-026 BUSY timeout counter: cleared on entry to BUSY, incremented each BUSY cycle with mem_ready_i = 0.
REQ-027 When the counter equals TIMEOUT-1 with mem_ready_i = 0: set rdata_q = 0 (loads only), set err_q, go to DONE.
REQ-028 mem_ready_i = 1 in the timeout cycle SHALL take priority over the timeout.
REQ-029 DONE: core_stall_o = 0, mem_req_o = 0, core_err_o = err_q; unconditionally go to IDLE; core_req_i ignored.
REQ-030 mem_ready_i SHALL be ignored outside BUSY.
REQ-031 core_rd_o SHALL equal rdata_q at all times; stores SHALL leave rdata_q unchanged.
REQ-032 Byte enables: B/BU -> 4'b0001 << addr[1:0]; H/HU -> 4'b0011 << (2*addr[1]); W -> 4'b1111.
REQ-033 Write data: B -> byte replicated ×4; H -> halfword replicated ×2; W -> unchanged.
REQ-034 Load data: select byte lane addr[1:0] or half lane addr[1]; sign-extend for B/H, zero-extend for BU/HU, W passed unchanged.
REQ-035 Latency: accept in cycle N; mem_ready_i first seen in cycle M ≥ N+1; DONE in cycle M+1; stall therefore lasts M-N+1 cycles, minimum 2.

Reset
REQ-036 rst_i = 1 SHALL immediately force state IDLE, counter = 0, rdata_q = 0, err_q = 0 and all latched request registers = 0, so every output reads 0.
REQ-037 Reset during BUSY SHALL drop mem_req_o asynchronously; a mem_ready_i arriving after reset is ignored.

Verification
REQ-038 SW addr 0x104, wd 0xDEADBEEF, ready in first BUSY cycle -> mem_req_o high 1 cycle, be 1111, addr 0x104, wd 0xDEADBEEF, stall high 2 cycles, err 0.
REQ-039 SB addr 0x203, wd 0x000000A5 -> be 1000, mem_addr_o 0x200, mem_wd_o 0xA5A5A5A5.
REQ-040 mem_rd_i = 0x80FF1234: LB 0x3 -> 0xFFFFFF80; LBU 0x3 -> 0x00000080; LH 0x2 -> 0xFFFF80FF; LHU 0x2 -> 0x000080FF; LW 0x0 -> 0x80FF1234.
REQ-041 LW addr 0x2 or size 3 -> core_err_o high for 1 cycle, stall 0, mem_req_o never high.
REQ-042 TIMEOUT = 16, mem_ready_i held 0 -> 16 BUSY cycles, then DONE with core_err_o = 1 and core_rd_o = 0; ready in the 16th cycle -> normal completion with err 0.
REQ-043 Assert rst_i in the 3rd BUSY cycle -> mem_req_o = 0 and core_stall_o = 0 with no clock edge, core_rd_o = 0; the next request completes normally.
